mux_scan_serializer: RTL and testbench
======================================

MUX_SCAN_SERIALIZER -- requirements
Module: mux_scan_serializer

Interface
REQ-001 SHALL have parameter IDLE_GAP, default 0, meaning the number of idle cycles inserted after a word's last bit before the next word is accepted (legal range 0..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_data, input, 16 bits: the parallel word to be scanned, one channel per bit.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-007 SHALL have port sel, output, 4 bits: the current channel select, driven to the downstream 16:1 selection stage.
REQ-008 SHALL have port out_bit, output, 1 bit: the held word bit indexed by sel.
REQ-009 SHALL have port out_valid, output, 1 bit: out_bit is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts out_bit.
REQ-011 SHALL have port out_last, output, 1 bit: out_bit is the final channel of the word.
REQ-012 SHALL have port busy, output, 1 bit: the block is not in IDLE.

Function
REQ-013 SHALL implement three states: IDLE, SHIFT and GAP.
REQ-014 SHALL drive in_ready=1 only in IDLE, and only while rst=0.
REQ-015 SHALL, in IDLE on in_valid=1: capture in_data into a 16-bit hold register, load sel with the start channel, and enter SHIFT on the next cycle.
REQ-016 SHALL drive out_valid=1 exactly while in SHIFT.
REQ-017 SHALL drive out_bit combinationally as hold[sel].
REQ-018 SHALL drive out_last=1 in SHIFT when sel equals the end channel.
REQ-019 SHALL advance sel by one step on each SHIFT cycle where out_valid and out_ready are both 1 and out_last=0.
REQ-020 SHALL, on an accepted beat with out_last=1: enter IDLE if IDLE_GAP=0, otherwise enter GAP with a counter loaded to IDLE_GAP.
REQ-021 SHALL, in GAP, decrement the counter each cycle and enter IDLE on the cycle it reaches 1.
REQ-022 SHALL hold sel, out_bit and out_last stable while out_valid=1 and out_ready=0, for any stall length.
REQ-023 SHALL ignore in_valid in SHIFT and GAP; in_data is not sampled there.
REQ-024 SHALL, with IDLE_GAP=0 and continuous handshakes, sustain one word per 17 cycles (1 accept cycle plus 16 beats).
REQ-025 SHALL restore sel to the start channel when returning to IDLE; sel does not wrap through 16.

Reset
REQ-026 SHALL, while rst=1 at a rising edge, set: state=IDLE, hold=16'h0000, sel=start channel, GAP counter=0.
REQ-027 SHALL produce these outputs after reset: out_valid=0, out_last=0, busy=0, out_bit=0; in_ready=1 once rst deasserts.
REQ-028 SHALL, on reset mid-word, discard the word with no further beats; out_valid=0 from the next cycle.

Configuration
REQ-029 SHALL, with macro MUX_SCAN_MSB_FIRST_EN defined, use start channel 15 and end channel 0, decrementing sel each beat.
REQ-030 SHALL, without MUX_SCAN_MSB_FIRST_EN, use start channel 0 and end channel 15, incrementing sel each beat.

Verification
REQ-031 Bench SHALL cover: reset, then in_data=16'hA5C3 with in_valid held 1 and out_ready=1 (LSB-first) -> beats 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; out_last=1 only on sel=15; in_ready=1 again at cycle 17.
REQ-032 Bench SHALL cover: the same word with MUX_SCAN_MSB_FIRST_EN -> sel sequence 15..0, first beat 1, out_last on sel=0.
REQ-033 Bench SHALL cover: out_ready=0 for 5 cycles at sel=7 -> sel, out_bit and out_last unchanged; resume yields sel=8.
REQ-034 Bench SHALL cover: IDLE_GAP=3 with back-to-back words -> exactly 3 cycles with busy=1, in_ready=0, out_valid=0 between a word's last beat and the next accept.
REQ-035 Bench SHALL cover: rst pulsed at sel=9 -> next cycle out_valid=0, sel=0, hold=0; the next word starts at channel 0.
REQ-036 Bench SHALL cover: in_valid toggling with random data during SHIFT -> output stream of the held word unaffected.

Source files
------------

// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer
//   Captures a 16-bit parallel word and scans it out one channel per beat by
//   driving a 4-bit channel select to a downstream 16:1 selection stage.
//   out_bit reflects the held word bit at the current select.
//   The bit order is set by the optional build macro MUX_SCAN_MSB_FIRST_EN:
//     undefined : start channel 0, end channel 15, sel increments each beat
//     defined   : start channel 15, end channel 0, sel decrements each beat
//
// Parameters
//   IDLE_GAP  : idle cycles inserted after a word's last beat before the
//               next word can be accepted (0..15)
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   in_data   : parallel word, one channel per bit
//   in_valid  : in_data is valid
//   in_ready  : a word is accepted this cycle (IDLE and not in reset)
//   sel       : current channel select
//   out_bit   : held word bit indexed by sel
//   out_valid : out_bit is valid (SHIFT state)
//   out_ready : consumer accepts out_bit
//   out_last  : out_bit is the word's final channel
//   busy      : block is not idle
module mux_scan_serializer #(
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  sel,
  output logic        out_bit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy
);

`ifdef MUX_SCAN_MSB_FIRST_EN
  localparam logic [3:0] START_CH  = 4'd15;
  localparam logic [3:0] END_CH    = 4'd0;
  localparam logic       MSB_FIRST = 1'b1;
`else
  localparam logic [3:0] START_CH  = 4'd0;
  localparam logic [3:0] END_CH    = 4'd15;
  localparam logic       MSB_FIRST = 1'b0;
`endif

  localparam logic [3:0] GAP_LOAD = 4'(IDLE_GAP);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]  state;
  logic [15:0] hold;
  logic [3:0]  gap_cnt;
  logic [3:0]  sel_next;

  assign sel_next  = MSB_FIRST ? (sel - 4'd1) : (sel + 4'd1);

  assign in_ready  = (state == ST_IDLE) && !rst;
  assign out_valid = (state == ST_SHIFT);
  assign out_last  = (state == ST_SHIFT) && (sel == END_CH);
  assign out_bit   = hold[sel];
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      hold    <= '0;
      sel     <= START_CH;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            hold  <= in_data;
            sel   <= START_CH;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (out_ready) begin
            if (sel == END_CH) begin
              // sel returns to the start channel here rather than wrapping
              sel <= START_CH;
              if (IDLE_GAP == 0) begin
                state <= ST_IDLE;
              end else begin
                state   <= ST_GAP;
                gap_cnt <= GAP_LOAD;
              end
            end else begin
              sel <= sel_next;
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - 4'd1;
          if (gap_cnt <= 4'd1) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Testbench for mux_scan_serializer: table-driven word scan plus directed
// sequences for stall, mid-word reset, in_valid noise and the IDLE_GAP=3 gap.
// Bit order follows MUX_SCAN_MSB_FIRST_EN, matching the design build.
module tb_mux_scan_serializer;

`ifdef MUX_SCAN_MSB_FIRST_EN
  localparam bit         MSB_FIRST = 1'b1;
  localparam logic [3:0] START_CH  = 4'd15;
`else
  localparam bit         MSB_FIRST = 1'b0;
  localparam logic [3:0] START_CH  = 4'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  sel;
  logic        out_bit;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;

  logic [15:0] g_in_data;
  logic        g_in_valid;
  logic        g_in_ready;
  logic [3:0]  g_sel;
  logic        g_out_bit;
  logic        g_out_valid;
  logic        g_out_ready;
  logic        g_out_last;
  logic        g_busy;

  always #5 clk = ~clk;

  mux_scan_serializer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .out_bit(out_bit), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy)
  );

  mux_scan_serializer #(.IDLE_GAP(3)) dut_gap (
    .clk(clk), .rst(rst), .in_data(g_in_data), .in_valid(g_in_valid),
    .in_ready(g_in_ready), .sel(g_sel), .out_bit(g_out_bit),
    .out_valid(g_out_valid), .out_ready(g_out_ready), .out_last(g_out_last),
    .busy(g_busy)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic        e_ol;
    logic        e_busy;
    logic [3:0]  e_sel;
    logic        e_bit;
  } vec_t;

  vec_t tbl [19];

  // Hand-listed LSB-first beats of 16'hA5C3 (bit 0 first)
  bit beats_lsb [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [3:0] sel_of(input int k);
    return MSB_FIRST ? 4'(15 - k) : 4'(k);
  endfunction

  function automatic logic beat_of(input int k);
    return MSB_FIRST ? beats_lsb[15 - k] : beats_lsb[k];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] w2;
    int          gap;
    bit          seen_ready;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    g_in_valid = 1'b0; g_in_data = '0; g_out_ready = 1'b1;

    // Build the vector table
    tbl[0] = '{rst:1'b1, iv:1'b0, d:16'h0000, ordy:1'b1, e_ir:1'b0, e_ov:1'b0,
               e_ol:1'b0, e_busy:1'b0, e_sel:START_CH, e_bit:1'b0};
    for (int i = 1; i <= 16; i++) begin
      tbl[i] = '{rst:1'b0, iv:1'b1, d:16'hA5C3, ordy:1'b1, e_ir:1'b0, e_ov:1'b1,
                 e_ol:(i == 16), e_busy:1'b1, e_sel:sel_of(i - 1),
                 e_bit:beat_of(i - 1)};
    end
    tbl[17] = '{rst:1'b0, iv:1'b1, d:16'hA5C3, ordy:1'b1, e_ir:1'b1, e_ov:1'b0,
                e_ol:1'b0, e_busy:1'b0, e_sel:START_CH, e_bit:beat_of(0)};
    tbl[18] = '{rst:1'b0, iv:1'b0, d:16'h0000, ordy:1'b1, e_ir:1'b1, e_ov:1'b0,
                e_ol:1'b0, e_busy:1'b0, e_sel:START_CH, e_bit:beat_of(0)};

    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].d;
      out_ready = tbl[i].ordy;
      step();
      chk($sformatf("tbl%0d_in_ready", i),  int'(in_ready),  int'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), int'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_out_last", i),  int'(out_last),  int'(tbl[i].e_ol));
      chk($sformatf("tbl%0d_busy", i),      int'(busy),      int'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_sel", i),       int'(sel),       int'(tbl[i].e_sel));
      chk($sformatf("tbl%0d_out_bit", i),   int'(out_bit),   int'(tbl[i].e_bit));
    end

    // Stall for 5 cycles at beat index 7
    in_valid = 1'b1; in_data = 16'hA5C3; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk("stall_pre_sel", int'(sel), int'(sel_of(7)));
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("stall%0d_sel", c),   int'(sel),       int'(sel_of(7)));
      chk($sformatf("stall%0d_bit", c),   int'(out_bit),   int'(beat_of(7)));
      chk($sformatf("stall%0d_last", c),  int'(out_last),  0);
      chk($sformatf("stall%0d_valid", c), int'(out_valid), 1);
    end
    out_ready = 1'b1;
    step();
    chk("stall_resume_sel", int'(sel), int'(sel_of(8)));
    chk("stall_resume_bit", int'(out_bit), int'(beat_of(8)));
    for (int k = 8; k < 16; k++) step();
    chk("stall_drain_busy", int'(busy), 0);

    // Reset at beat index 9
    w = 16'hF00F;
    in_valid = 1'b1; in_data = w;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 9; k++) step();
    chk("rstmid_pre_sel", int'(sel), int'(sel_of(9)));
    rst = 1'b1;
    step();
    chk("rstmid_out_valid", int'(out_valid), 0);
    chk("rstmid_sel",       int'(sel),       int'(START_CH));
    chk("rstmid_out_bit",   int'(out_bit),   0);
    chk("rstmid_busy",      int'(busy),      0);
    chk("rstmid_in_ready",  int'(in_ready),  0);
    rst = 1'b0;
    #1;
    chk("rstmid_ready_after", int'(in_ready), 1);
    w2 = 16'h0006;
    in_valid = 1'b1; in_data = w2;
    step();
    chk("rstmid_w2_sel0", int'(sel),     int'(START_CH));
    chk("rstmid_w2_bit0", int'(out_bit), int'(w2[sel_of(0)]));
    in_valid = 1'b0;
    step();
    chk("rstmid_w2_sel1", int'(sel),     int'(sel_of(1)));
    chk("rstmid_w2_bit1", int'(out_bit), int'(w2[sel_of(1)]));
    for (int k = 1; k < 16; k++) step();
    chk("rstmid_drain_busy", int'(busy), 0);

    // in_valid toggling with random data while shifting
    w = 16'h5AF0;
    in_valid = 1'b1; in_data = w;
    step();
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("noise%0d_sel", k),  int'(sel),      int'(sel_of(k)));
      chk($sformatf("noise%0d_bit", k),  int'(out_bit),  int'(w[sel_of(k)]));
      chk($sformatf("noise%0d_last", k), int'(out_last), int'(k == 15));
      in_valid = (k % 2 == 0);
      in_data  = 16'($urandom());
      step();
    end
    in_valid = 1'b0;
    chk("noise_end_busy", int'(busy), 0);

    // IDLE_GAP=3 with back-to-back words
    w = 16'hA5C3; w2 = 16'h0F0F;
    chk("gap_idle_ready", int'(g_in_ready), 1);
    g_in_valid = 1'b1; g_in_data = w;
    step();
    g_in_data = w2;
    for (int k = 0; k < 15; k++) step();
    chk("gap_last_flag", int'(g_out_last), 1);
    step();
    gap = 0;
    seen_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (g_in_ready) begin
        seen_ready = 1'b1;
        break;
      end
      if (g_busy && !g_out_valid) gap++;
      step();
    end
    chk("gap_ready_seen", int'(seen_ready), 1);
    chk("gap_len", gap, 3);
    step();
    chk("gap_w2_valid", int'(g_out_valid), 1);
    chk("gap_w2_sel",   int'(g_sel),       int'(START_CH));
    chk("gap_w2_bit",   int'(g_out_bit),   int'(w2[sel_of(0)]));
    g_in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
